prog_loader: RTL and testbench

PROG_LOADER -- requirements
Module: prog_loader

---
 rtl/prog_loader.sv | 115 +++++++++++
 tb/tb_prog_loader.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/prog_loader.sv
// rtl/prog_loader.sv - serial byte program loader with XOR checksum and CPU hold
module prog_loader (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [5:0]  load_len,
    input  logic [7:0]  byte_in,
    input  logic        byte_valid,
    output logic        byte_ready,
    output logic        wr_en,
    output logic [4:0]  wr_addr,
    output logic [31:0] wr_data,
    output logic        cpu_hold,
    output logic        busy,
    output logic        done,
    output logic        err
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LOAD  = 3'd1;
    localparam logic [2:0] S_CHECK = 3'd2;
    localparam logic [2:0] S_DONE  = 3'd3;
    localparam logic [2:0] S_ERR   = 3'd4;

    logic [2:0]  state;
    logic [2:0]  state_n;
    logic [1:0]  byte_cnt;
    logic [5:0]  word_cnt;
    logic [5:0]  len;
    logic [23:0] asm_q;
    logic [31:0] acc;

    logic        accept;
    logic        last_byte;
    logic        len_ok;
    logic        can_start;
    logic [31:0] word_full;

    assign accept    = byte_valid & byte_ready;
    assign last_byte = accept && (byte_cnt == 2'd3);
    assign len_ok    = (load_len != 6'd0) && (load_len <= 6'd32);
    assign can_start = (state == S_IDLE) || (state == S_DONE) || (state == S_ERR);
    // The word completes with the byte being accepted, so the write and the
    // checksum compare both see it without an extra assembly cycle.
    assign word_full = {asm_q, byte_in};

    always_comb begin
        state_n = state;
        case (state)
            S_IDLE, S_DONE, S_ERR: begin
                if (start) begin
                    state_n = len_ok ? S_LOAD : S_ERR;
                end
            end
            S_LOAD: begin
                if (last_byte && (word_cnt == len - 6'd1)) begin
                    state_n = S_CHECK;
                end
            end
            S_CHECK: begin
                if (last_byte) begin
                    state_n = (word_full == acc) ? S_DONE : S_ERR;
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            byte_cnt   <= 2'd0;
            word_cnt   <= 6'd0;
            len        <= 6'd0;
            asm_q      <= 24'd0;
            acc        <= 32'd0;
            byte_ready <= 1'b0;
            wr_en      <= 1'b0;
            wr_addr    <= 5'd0;
            wr_data    <= 32'd0;
            cpu_hold   <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
        end else begin
            state      <= state_n;
            wr_en      <= 1'b0;
            byte_ready <= (state_n == S_LOAD) || (state_n == S_CHECK);
            busy       <= (state_n == S_LOAD) || (state_n == S_CHECK);
            cpu_hold   <= (state_n == S_LOAD) || (state_n == S_CHECK) || (state_n == S_ERR);
            done       <= (state_n == S_DONE);
            err        <= (state_n == S_ERR);

            if (can_start && start && len_ok) begin
                byte_cnt <= 2'd0;
                word_cnt <= 6'd0;
                len      <= load_len;
                asm_q    <= 24'd0;
                acc      <= 32'd0;
            end else if (accept) begin
                asm_q    <= word_full[23:0];
                byte_cnt <= byte_cnt + 2'd1;
                // Checksum bytes are only assembled; memory sees data words only.
                if (last_byte && (state == S_LOAD)) begin
                    wr_en    <= 1'b1;
                    wr_addr  <= word_cnt[4:0];
                    wr_data  <= word_full;
                    word_cnt <= word_cnt + 6'd1;
                    acc      <= acc ^ word_full;
                end
            end
        end
    end

endmodule

// File: tb/tb_prog_loader.sv
// tb/tb_prog_loader.sv - scoreboard bench for prog_loader with a word-level reference model
module tb_prog_loader;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [5:0]  load_len = 6'd0;
    logic [7:0]  byte_in = 8'd0;
    logic        byte_valid = 1'b0;
    logic        byte_ready;
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic        cpu_hold;
    logic        busy;
    logic        done;
    logic        err;

    prog_loader dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .load_len   (load_len),
        .byte_in    (byte_in),
        .byte_valid (byte_valid),
        .byte_ready (byte_ready),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .cpu_hold   (cpu_hold),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_fail = 0;
    logic [36:0] exp_q[$];
    logic [36:0] mon_e;
    logic [31:0] w [32];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every write strobe must match the next expected (addr, data).
    always @(negedge clk) begin
        if (!rst && wr_en) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_write: got addr %0d data %h expected no write", wr_addr, wr_data);
            end else begin
                mon_e = exp_q.pop_front();
                check("wr_addr", {27'd0, wr_addr}, {27'd0, mon_e[36:32]});
                check("wr_data", wr_data, mon_e[31:0]);
            end
        end
    end

    task automatic do_start(input logic [5:0] len);
        start    = 1'b1;
        load_len = len;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit gap, input bit pulse);
        int cnt;
        cnt        = 0;
        byte_in    = b;
        byte_valid = 1'b1;
        @(negedge clk);
        while (!byte_ready && cnt < 50) begin
            @(negedge clk);
            cnt++;
        end
        if (!byte_ready) begin
            n_checks++;
            n_fail++;
            $display("FAIL byte_accept: got byte_ready 0 expected 1 within 50 cycles");
            byte_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        byte_valid = 1'b0;
        if (gap) begin
            if (pulse) begin
                start    = 1'b1;
                load_len = 6'd5;
            end
            @(posedge clk);
            #1;
            start = 1'b0;
        end
    endtask

    task automatic send_word(input logic [31:0] word, input bit gap, input bit pulse);
        for (int i = 3; i >= 0; i--) begin
            send_byte(word[8*i +: 8], gap, pulse && (i == 3));
        end
    endtask

    task automatic wait_status();
        int cnt;
        cnt = 0;
        @(negedge clk);
        while (!(done || err) && cnt < 20) begin
            @(negedge clk);
            cnt++;
        end
    endtask

    // Reference: the load writes w[0..len-1] at addresses 0..len-1 and succeeds
    // exactly when the checksum equals the XOR of those words.
    task automatic run_load(input int len, input logic [31:0] chkw, input bit gap, input bit pulse);
        logic [31:0] x;
        bit          good;
        x = 32'd0;
        for (int i = 0; i < len; i++) begin
            exp_q.push_back({i[4:0], w[i]});
            x = x ^ w[i];
        end
        good = (x == chkw);
        do_start(len[5:0]);
        for (int i = 0; i < len; i++) begin
            send_word(w[i], gap, pulse && (i == 1));
        end
        send_word(chkw, gap, 1'b0);
        wait_status();
        check("done", {31'd0, done}, {31'd0, good});
        check("err", {31'd0, err}, {31'd0, !good});
        check("cpu_hold", {31'd0, cpu_hold}, {31'd0, !good});
        check("busy", {31'd0, busy}, 32'd0);
        check("byte_ready_end", {31'd0, byte_ready}, 32'd0);
        check("writes_pending", exp_q.size(), 32'd0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_byte_ready"}, {31'd0, byte_ready}, 32'd0);
        check({tag, "_wr_en"}, {31'd0, wr_en}, 32'd0);
        check({tag, "_wr_addr"}, {27'd0, wr_addr}, 32'd0);
        check({tag, "_wr_data"}, wr_data, 32'd0);
        check({tag, "_cpu_hold"}, {31'd0, cpu_hold}, 32'd0);
        check({tag, "_busy"}, {31'd0, busy}, 32'd0);
        check({tag, "_done"}, {31'd0, done}, 32'd0);
        check({tag, "_err"}, {31'd0, err}, 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: got no finish expected finish within 1 ms");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] x;
        int          len;

        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check_all_zero("reset");

        // Nominal load, then the same load with a wrong checksum.
        @(posedge clk);
        #1;
        w[0] = 32'h12345678;
        w[1] = 32'h9ABCDEF0;
        run_load(2, 32'h88888888, 1'b0, 1'b0);
        run_load(2, 32'h00000000, 1'b0, 1'b0);

        // Illegal lengths go straight to ERR with no writes.
        do_start(6'd0);
        @(negedge clk);
        check("len0_err", {31'd0, err}, 32'd1);
        check("len0_ready", {31'd0, byte_ready}, 32'd0);
        check("len0_hold", {31'd0, cpu_hold}, 32'd1);
        @(posedge clk);
        #1;
        run_load(1, 32'h0, 1'b0, 1'b0);
        do_start(6'd33);
        @(negedge clk);
        check("len33_err", {31'd0, err}, 32'd1);
        check("len33_done", {31'd0, done}, 32'd0);
        check("len33_ready", {31'd0, byte_ready}, 32'd0);
        repeat (5) @(posedge clk);
        #1;

        // Full 32-word load; word n = n so the XOR is zero.
        for (int i = 0; i < 32; i++) w[i] = i;
        run_load(32, 32'h0, 1'b0, 1'b0);

        // Reset after the 2nd byte of word 1: only word 0 is written.
        w[0] = $urandom;
        w[1] = $urandom;
        exp_q.push_back({5'd0, w[0]});
        do_start(6'd2);
        send_word(w[0], 1'b0, 1'b0);
        x = w[1];
        send_byte(x[31:24], 1'b0, 1'b0);
        send_byte(x[23:16], 1'b0, 1'b0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check_all_zero("midrst");
        repeat (10) @(posedge clk);
        #1;
        check("midrst_pending", exp_q.size(), 32'd0);
        w[0] = $urandom;
        w[1] = $urandom;
        run_load(2, w[0] ^ w[1], 1'b0, 1'b0);

        // Valid gaps with a start pulse mid-load that must be ignored.
        for (int i = 0; i < 3; i++) w[i] = $urandom;
        run_load(3, w[0] ^ w[1] ^ w[2], 1'b1, 1'b1);

        // Randomized loads, good or bad checksum, with or without gaps.
        for (int k = 0; k < 8; k++) begin
            len = $urandom_range(1, 6);
            x = 32'd0;
            for (int i = 0; i < len; i++) begin
                w[i] = $urandom;
                x = x ^ w[i];
            end
            if ($urandom_range(0, 1) == 1) x = x ^ ($urandom | 32'd1);
            run_load(len, x, $urandom_range(0, 1) == 1, 1'b0);
        end

        repeat (5) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
